dso100fb_video_mix_layers: RTL
==============================

Name: dso100fb_video_mix_layers

Overview:
- N-layer pixel compositor between the framebuffer/overlay FIFOs and the video output stage.
- Layer 0 is the base video; layers 1..LAYERS-1 are overlays, each with its own mixing mode.
- Per-layer FIFO valid tracking and sync/DE delay matching are built in.
- Modes are double-buffered and swap at VSYNC rise; a saturating base-layer underrun counter is provided.

Parameters:
- LAYERS, 2, number of layers including base; must be >= 2
- CHANNELS, 4, channels per pixel
- CHAN_W, 8, bits per channel (unsigned)
- CNT_W, 16, underrun counter width

Ports:
- VIDCLK  in  1  pixel clock
- RST  in  1  reset; one clock; reset is synchronous and active-high
- LAYER_FETCH  in  LAYERS  layer i FIFO read strobe in this cycle
- LAYER_EMPTY  in  LAYERS  layer i FIFO empty in this cycle
- LAYER_DATA  in  LAYERS*CHANNELS*CHAN_W  layer i word, slice [i*PW +: PW] where PW=CHANNELS*CHAN_W; valid one cycle after its fetch
- LAYER_MODE  in  2*(LAYERS-1)  requested mode of layer k (k>=1) at [(k-1)*2 +: 2]
- DE, HSYNC, VSYNC  in  1 each  timing from the sync generator, aligned with LAYER_FETCH
- UNDERRUN_CLR  in  1  clears the underrun counter
- VID_DATA  out  CHANNELS*CHAN_W  mixed pixel
- VID_DE, VID_HSYNC, VID_VSYNC  out  1 each  delayed timing
- UNDERRUN_COUNT  out  CNT_W  base-layer underrun pixel count

Behaviour:
- Reset (RST=1 at a VIDCLK edge): VID_DATA=0, VID_DE/HSYNC/VSYNC=0, UNDERRUN_COUNT=0, all active modes=OFF, all pipeline valids/syncs=0.
- Layer valid: v_i(t) = LAYER_FETCH[i] && !LAYER_EMPTY[i]; the data for pixel t is LAYER_DATA at t+1.
- Masking: a layer contribution is zero unless both v_i and that pixel's DE are 1.
  - Base layer masked → base contributes 0.
  - Overlay masked → that stage passes the accumulator unchanged.
- Modes (2-bit, per channel, unsigned CHAN_W):
  - 0 OFF: pass the accumulator.
  - 1 ADD: min(acc+layer, 2^CHAN_W-1).
  - 2 KEY: result = layer word if the whole layer pixel is nonzero, else acc. Transparency is decided per pixel, not per channel.
  - 3 SUB: max(acc-layer, 0).
- Order: acc0 = base; stage k applies layer k to acc(k-1), k = 1..LAYERS-1 ascending.
- Pipeline: one register stage per layer.
  - Latency from DE/HSYNC/VSYNC sampled at edge E0 to VID_* updated = LAYERS edges; VID_DATA belongs to the same pixel as VID_DE.
  - For LAYERS=2, latency = 2 edges.
  - Layer k data is delayed internally to meet its stage; throughput is one pixel per clock with no stalls.
- Mode shadowing:
  - LAYER_MODE is loaded into the active mode register only on the cycle where VSYNC=1 and the previously sampled VSYNC=0.
  - The new modes apply from the next edge. Mid-frame changes on LAYER_MODE have no effect.
  - Legal timing guarantees at least LAYERS blanking cycles around the VSYNC rise, so no in-flight DE pixel sees a mode change.
- Underrun: increment when DE && LAYER_FETCH[0] && LAYER_EMPTY[0].
  - Saturates at 2^CNT_W-1.
  - UNDERRUN_CLR has priority over a simultaneous increment; the result is 0.
- Reset mid-frame: the pipeline flushes to zeros; output resumes valid LAYERS edges after RST deasserts; modes revert to OFF until the next VSYNC rise.

Decomposition:
- Package dso100fb_video_mix_pkg:
  - mode constants MIX_OFF/MIX_ADD/MIX_KEY/MIX_SUB
  - a 2-bit mode typedef
- Sub-module dso100fb_video_mix_stage: one registered stage, CHANNELS parallel per-channel operators plus whole-pixel key detect. Instantiated LAYERS-1 times by a generate loop.
- Base capture, valid/sync delay lines, mode shadow and counter live in the top.

Test Plan:
1. Defaults (LAYERS=2, CHAN_W=8), mode1=ADD latched by VSYNC, DE=1, both valid: base 0x10F0_8040, overlay 0x0120_9010 → VID_DATA 0x11FF_FF50 exactly 2 edges after DE, VID_DE=1 that cycle.
2. KEY mode: overlay 0x0000_0000 with base 0xAABB_CCDD → 0xAABB_CCDD; overlay 0x0000_0001 → 0x0000_0001. SUB mode: base 0x05, overlay 0x09 in channel 0 → 0x00.
3. LAYER_MODE changed from ADD to OFF mid-line → output keeps ADD results until after the next VSYNC 0→1, then equals the base pixel.
4. Base EMPTY=1 with FETCH=1, DE=1 for 3 pixels → those VID_DATA = overlay only; UNDERRUN_COUNT=3. UNDERRUN_CLR together with an underrun pixel → count 0.
5. CNT_W=2: 5 underrun pixels → count holds at 3.
6. LAYERS=3 (ADD then KEY): latency 3 edges. Assert RST mid-line for one cycle → all VID_* = 0 next edge, and modes OFF until the next VSYNC rise.

Source files
------------

// File: rtl/dso100fb_video_mix_pkg.sv
// Shared mixing-mode encoding for the layer compositor and its per-layer stages.
package dso100fb_video_mix_pkg;

    typedef logic [1:0] mix_mode_t;

    localparam mix_mode_t MIX_OFF = 2'd0;
    localparam mix_mode_t MIX_ADD = 2'd1;
    localparam mix_mode_t MIX_KEY = 2'd2;
    localparam mix_mode_t MIX_SUB = 2'd3;

endpackage

// File: rtl/dso100fb_video_mix_stage.sv
// One registered overlay stage: applies a single layer to the running accumulator.
module dso100fb_video_mix_stage
    import dso100fb_video_mix_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CHAN_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode,
    input  logic                         en,
    input  logic [CHANNELS*CHAN_W-1:0]   acc_in,
    input  logic [CHANNELS*CHAN_W-1:0]   layer,
    output logic [CHANNELS*CHAN_W-1:0]   acc_out
);

    logic [CHANNELS*CHAN_W-1:0] mixed;
    logic [CHAN_W:0]            sum;
    logic [CHAN_W-1:0]          a;
    logic [CHAN_W-1:0]          l;

    always_comb begin
        mixed = acc_in;
        sum   = '0;
        a     = '0;
        l     = '0;
        if (en) begin
            case (mode)
                MIX_ADD: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        a   = acc_in[c*CHAN_W +: CHAN_W];
                        l   = layer[c*CHAN_W +: CHAN_W];
                        sum = {1'b0, a} + {1'b0, l};
                        mixed[c*CHAN_W +: CHAN_W] = sum[CHAN_W] ? {CHAN_W{1'b1}} : sum[CHAN_W-1:0];
                    end
                end
                // Transparency is a whole-pixel decision: any nonzero channel makes the pixel opaque.
                MIX_KEY: begin
                    if (layer != '0) mixed = layer;
                end
                MIX_SUB: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        a = acc_in[c*CHAN_W +: CHAN_W];
                        l = layer[c*CHAN_W +: CHAN_W];
                        mixed[c*CHAN_W +: CHAN_W] = (a > l) ? a - l : '0;
                    end
                end
                default: mixed = acc_in;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) acc_out <= '0;
        else     acc_out <= mixed;
    end

endmodule

// File: rtl/dso100fb_video_mix_layers.sv
// N-layer pixel compositor: base capture, per-overlay stages, timing delay match,
// VSYNC-shadowed modes and a saturating base-layer underrun counter.
module dso100fb_video_mix_layers
    import dso100fb_video_mix_pkg::*;
#(
    parameter int LAYERS   = 2,
    parameter int CHANNELS = 4,
    parameter int CHAN_W   = 8,
    parameter int CNT_W    = 16
) (
    input  logic                                VIDCLK,
    input  logic                                RST,
    input  logic [LAYERS-1:0]                   LAYER_FETCH,
    input  logic [LAYERS-1:0]                   LAYER_EMPTY,
    input  logic [LAYERS*CHANNELS*CHAN_W-1:0]   LAYER_DATA,
    input  logic [2*(LAYERS-1)-1:0]             LAYER_MODE,
    input  logic                                DE,
    input  logic                                HSYNC,
    input  logic                                VSYNC,
    input  logic                                UNDERRUN_CLR,
    output logic [CHANNELS*CHAN_W-1:0]          VID_DATA,
    output logic                                VID_DE,
    output logic                                VID_HSYNC,
    output logic                                VID_VSYNC,
    output logic [CNT_W-1:0]                    UNDERRUN_COUNT
);

    localparam int PW = CHANNELS * CHAN_W;
    localparam int MW = 2 * (LAYERS - 1);

    logic [LAYERS:0]      de_sr;
    logic [LAYERS:0]      hs_sr;
    logic [LAYERS:0]      vs_sr;
    logic                 base_vld;
    logic [PW-1:0]        base_q;
    logic [LAYERS*PW-1:0] acc;
    logic [MW-1:0]        mode_act;
    logic [CNT_W-1:0]     underrun_cnt;
    logic                 vsync_rise;

    // vs_sr[0] is the VSYNC sampled on the previous edge.
    assign vsync_rise = VSYNC & ~vs_sr[0];

    always_ff @(posedge VIDCLK) begin
        if (RST) begin
            de_sr        <= '0;
            hs_sr        <= '0;
            vs_sr        <= '0;
            base_vld     <= 1'b0;
            base_q       <= '0;
            mode_act     <= {(LAYERS-1){MIX_OFF}};
            underrun_cnt <= '0;
        end else begin
            de_sr    <= {de_sr[LAYERS-1:0], DE};
            hs_sr    <= {hs_sr[LAYERS-1:0], HSYNC};
            vs_sr    <= {vs_sr[LAYERS-1:0], VSYNC};
            base_vld <= LAYER_FETCH[0] & ~LAYER_EMPTY[0] & DE;
            base_q   <= base_vld ? LAYER_DATA[PW-1:0] : '0;
            if (vsync_rise) mode_act <= LAYER_MODE;
            if (UNDERRUN_CLR)
                underrun_cnt <= '0;
            else if (DE && LAYER_FETCH[0] && LAYER_EMPTY[0] && underrun_cnt != {CNT_W{1'b1}})
                underrun_cnt <= underrun_cnt + CNT_W'(1);
        end
    end

    assign acc[PW-1:0] = base_q;

    for (genvar k = 1; k < LAYERS; k++) begin : g_layer
        logic [k:0]    vld_sr;
        logic [PW-1:0] data_sr [k];

        always_ff @(posedge VIDCLK) begin
            if (RST) vld_sr <= '0;
            else     vld_sr <= {vld_sr[k-1:0], LAYER_FETCH[k] & ~LAYER_EMPTY[k] & DE};
        end

        // Data carries no reset: it only reaches the output when its valid bit is set.
        always_ff @(posedge VIDCLK) begin
            data_sr[0] <= LAYER_DATA[k*PW +: PW];
            for (int i = 1; i < k; i++) data_sr[i] <= data_sr[i-1];
        end

        dso100fb_video_mix_stage #(
            .CHANNELS(CHANNELS),
            .CHAN_W  (CHAN_W)
        ) u_stage (
            .clk    (VIDCLK),
            .rst    (RST),
            .mode   (mode_act[(k-1)*2 +: 2]),
            .en     (vld_sr[k]),
            .acc_in (acc[(k-1)*PW +: PW]),
            .layer  (data_sr[k-1]),
            .acc_out(acc[k*PW +: PW])
        );
    end

    assign VID_DATA       = acc[(LAYERS-1)*PW +: PW];
    assign VID_DE         = de_sr[LAYERS];
    assign VID_HSYNC      = hs_sr[LAYERS];
    assign VID_VSYNC      = vs_sr[LAYERS];
    assign UNDERRUN_COUNT = underrun_cnt;

endmodule
